// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: request/response bundles, memory op
// encodings and the LSU state enum.
package load_store_unit_pkg;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} LsuState;

  typedef struct packed {
    logic [31:0] addr;
    logic        fcn;
    logic [2:0]  typ;
    logic [31:0] data;
  } MemReq;

  typedef struct packed {
    logic  req_valid;
    MemReq req;
  } MemoryIn;

  typedef struct packed {
    logic [31:0] data;
  } MemResp;

  typedef struct packed {
    MemResp res;
  } MemoryOut;

  // Halfwords must sit on even bytes and words on word boundaries.
  function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if ((typ == MT_H) || (typ == MT_HU)) mis = offset[0];
    else if (typ == MT_W)                mis = (offset != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for the LSU: byte enables and replicated store data, plus load-lane
// extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = load_word[{offset, 3'b000} +: 8];
  assign lane_h = load_word[{offset[1], 4'b0000} +: 16];

  // Sub-word accesses ignore offset bits below their own size.
  always_comb begin
    be        = 4'hF;
    wdata     = store_data;
    load_data = load_word;
    case (typ)
      MT_B: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{lane_b[7]}}, lane_b};
      end
      MT_BU: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'h0, lane_b};
      end
      MT_H: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{lane_h[15]}}, lane_h};
      end
      MT_HU: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {16'h0, lane_h};
      end
      default: begin
        be        = 4'hF;
        wdata     = store_data;
        load_data = load_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage data port: turns a pipeline memory request into one valid/ready bus transaction
// and stalls the core until it completes. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  MemoryIn     dmem_in,
  output MemoryOut    dmem_out,
  output logic        cmiss_stall,
  output logic        exc_misaligned,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  LsuState     state;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic [1:0]  req_off;
  logic [31:0] rdata_q;

  logic [2:0]  al_typ;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  // In IDLE the aligner sees the incoming request; afterwards it formats against the held one.
  assign al_typ = (state == IDLE) ? dmem_in.req.typ       : req_typ;
  assign al_off = (state == IDLE) ? dmem_in.req.addr[1:0] : req_off;

  lsu_align u_align (
    .typ        (al_typ),
    .offset     (al_off),
    .store_data (dmem_in.req.data),
    .load_word  (bus_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  assign cmiss_stall       = dmem_in.req_valid && (state != DONE);
  assign dmem_out.res.data = rdata_q;

`ifndef LSU_MISALIGN_TRAP_EN
  assign exc_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_fcn       <= M_XRD;
      req_typ       <= MT_X;
      req_off       <= 2'b00;
      rdata_q       <= 32'h0;
      bus_req_valid <= 1'b0;
      bus_addr      <= 32'h0;
      bus_we        <= 1'b0;
      bus_be        <= 4'h0;
      bus_wdata     <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dmem_in.req_valid) begin
            req_fcn <= dmem_in.req.fcn;
            req_typ <= dmem_in.req.typ;
            req_off <= dmem_in.req.addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(dmem_in.req.typ, dmem_in.req.addr[1:0])) begin
              rdata_q        <= 32'h0;
              exc_misaligned <= 1'b1;
              state          <= DONE;
            end else
`endif
            begin
              bus_req_valid <= 1'b1;
              bus_addr      <= {dmem_in.req.addr[31:2], 2'b00};
              bus_we        <= (dmem_in.req.fcn == M_XWR);
              bus_be        <= al_be;
              bus_wdata     <= al_wdata;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= (req_fcn == M_XWR) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            rdata_q <= al_load;
            state   <= DONE;
          end
        end
        DONE: begin
`ifdef LSU_MISALIGN_TRAP_EN
          exc_misaligned <= 1'b0;
`endif
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with hand-written reset and idle-bus sequences.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        reset;
  MemoryIn     dmem_in;
  MemoryOut    dmem_out;
  logic        cmiss_stall;
  logic        exc_misaligned;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [2:0]  typ;
    logic        fcn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          ready_delay;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        chk_res;
    logic [31:0] exp_res;
    int          exp_stalls;
    int          exp_exc;
  } vec_t;

  vec_t vecs[$];

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .dmem_in        (dmem_in),
    .dmem_out       (dmem_out),
    .cmiss_stall    (cmiss_stall),
    .exc_misaligned (exc_misaligned),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_addr       (bus_addr),
    .bus_we         (bus_we),
    .bus_be         (bus_be),
    .bus_wdata      (bus_wdata),
    .bus_rsp_valid  (bus_rsp_valid),
    .bus_rdata      (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Plays the datapath and the bus for one request; entered and left just after a negedge.
  task automatic apply_stimulus(input vec_t v);
    int stalls, exc_pulses, wait_cnt, unstable;
    logic seen_req, rsp_due, done;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    stalls = 0; exc_pulses = 0; wait_cnt = 0; unstable = 0;
    seen_req = 1'b0; rsp_due = 1'b0; done = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    dmem_in.req_valid = 1'b1;
    dmem_in.req.addr  = v.addr;
    dmem_in.req.fcn   = v.fcn;
    dmem_in.req.typ   = v.typ;
    dmem_in.req.data  = v.data;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (exc_misaligned) exc_pulses++;
      if (!cmiss_stall) done = 1'b1;
      else begin
        stalls++;
        bus_rsp_valid = 1'b0;
        bus_req_ready = 1'b0;
        if (rsp_due) begin
          bus_rsp_valid = 1'b1;
          bus_rdata     = v.rdata;
          rsp_due       = 1'b0;
        end
        if (bus_req_valid) begin
          if (!seen_req) begin
            seen_req = 1'b1;
            cap_addr = bus_addr; cap_be = bus_be; cap_we = bus_we; cap_wdata = bus_wdata;
          end else if ({bus_addr, bus_be, bus_we, bus_wdata} !== {cap_addr, cap_be, cap_we, cap_wdata})
            unstable++;
          if (wait_cnt >= v.ready_delay) begin
            bus_req_ready = 1'b1;
            rsp_due = (v.fcn == M_XRD);
          end
          wait_cnt++;
        end
        @(negedge clk);
      end
    end
    check_output({v.name, " completed"}, {31'h0, done}, 32'h1);
    check_output({v.name, " stall cycles"}, stalls, v.exp_stalls);
    check_output({v.name, " exc pulses"}, exc_pulses, v.exp_exc);
    check_output({v.name, " bus request issued"}, {31'h0, seen_req}, {31'h0, v.exp_req});
    if (v.exp_req) begin
      check_output({v.name, " bus_addr"}, cap_addr, v.exp_addr);
      check_output({v.name, " bus_be"}, {28'h0, cap_be}, {28'h0, v.exp_be});
      check_output({v.name, " bus_we"}, {31'h0, cap_we}, {31'h0, v.exp_we});
      check_output({v.name, " bus_wdata"}, cap_wdata, v.exp_wdata);
      check_output({v.name, " request stable"}, unstable, 0);
    end
    if (v.chk_res) check_output({v.name, " res.data"}, dmem_out.res.data, v.exp_res);
    dmem_in.req_valid = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b0;
    @(negedge clk);
    #1;
    check_output({v.name, " exc cleared after DONE"}, {31'h0, exc_misaligned}, 32'h0);
    check_output({v.name, " idle stall low"}, {31'h0, cmiss_stall}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{"LW 0x100",  MT_W,  M_XRD, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b1, 32'h100, 4'hF,    32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 3, 0});
    vecs.push_back('{"LB 0x103",  MT_B,  M_XRD, 32'h103, 32'h0,        32'h80000000, 0, 1'b1, 32'h100, 4'b1000, 32'h0,        1'b0, 1'b1, 32'hFFFFFF80, 3, 0});
    vecs.push_back('{"LBU 0x103", MT_BU, M_XRD, 32'h103, 32'h0,        32'h80000000, 0, 1'b1, 32'h100, 4'b1000, 32'h0,        1'b0, 1'b1, 32'h00000080, 3, 0});
    vecs.push_back('{"LHU 0x102", MT_HU, M_XRD, 32'h102, 32'h0,        32'h80000000, 0, 1'b1, 32'h100, 4'b1100, 32'h0,        1'b0, 1'b1, 32'h00008000, 3, 0});
    vecs.push_back('{"LH 0x100",  MT_H,  M_XRD, 32'h100, 32'h0,        32'h1234F00D, 0, 1'b1, 32'h100, 4'b0011, 32'h0,        1'b0, 1'b1, 32'hFFFFF00D, 3, 0});
    vecs.push_back('{"LB 0x101",  MT_B,  M_XRD, 32'h101, 32'h0,        32'h11227F33, 0, 1'b1, 32'h100, 4'b0010, 32'h0,        1'b0, 1'b1, 32'h0000007F, 3, 0});
    vecs.push_back('{"SH 0x202",  MT_H,  M_XWR, 32'h202, 32'h0000ABCD, 32'h0,        0, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 32'h0,        2, 0});
    vecs.push_back('{"SB 0x301",  MT_B,  M_XWR, 32'h301, 32'h12345678, 32'h0,        0, 1'b1, 32'h300, 4'b0010, 32'h78787878, 1'b1, 1'b0, 32'h0,        2, 0});
    vecs.push_back('{"SW 0x400",  MT_W,  M_XWR, 32'h400, 32'hCAFEF00D, 32'h0,        0, 1'b1, 32'h400, 4'hF,    32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        2, 0});
    vecs.push_back('{"LW slow",   MT_W,  M_XRD, 32'h500, 32'h0,        32'h0BADF00D, 5, 1'b1, 32'h500, 4'hF,    32'h0,        1'b0, 1'b1, 32'h0BADF00D, 8, 0});
    vecs.push_back('{"SW slow",   MT_W,  M_XWR, 32'h700, 32'h11112222, 32'h0,        2, 1'b1, 32'h700, 4'hF,    32'h11112222, 1'b1, 1'b0, 32'h0,        4, 0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{"LW 0x102",  MT_W,  M_XRD, 32'h102, 32'h0,        32'h01020304, 0, 1'b0, 32'h0,   4'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1, 1});
    vecs.push_back('{"LH 0x103",  MT_H,  M_XRD, 32'h103, 32'h0,        32'h80010000, 0, 1'b0, 32'h0,   4'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1, 1});
`else
    vecs.push_back('{"LW 0x102",  MT_W,  M_XRD, 32'h102, 32'h0,        32'h01020304, 0, 1'b1, 32'h100, 4'hF,    32'h0,        1'b0, 1'b1, 32'h01020304, 3, 0});
    vecs.push_back('{"LH 0x103",  MT_H,  M_XRD, 32'h103, 32'h0,        32'h80010000, 0, 1'b1, 32'h100, 4'b1100, 32'h0,        1'b0, 1'b1, 32'hFFFF8001, 3, 0});
`endif

    reset = 1'b1;
    dmem_in = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("reset bus_req_valid", {31'h0, bus_req_valid}, 32'h0);
    check_output("reset bus_we", {31'h0, bus_we}, 32'h0);
    check_output("reset bus_be", {28'h0, bus_be}, 32'h0);
    check_output("reset exc_misaligned", {31'h0, exc_misaligned}, 32'h0);
    check_output("reset res.data", dmem_out.res.data, 32'h0);
    check_output("reset stall", {31'h0, cmiss_stall}, 32'h0);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // A stray response or ready while idle must not disturb the held result or start a request.
    apply_stimulus('{"LW idle", MT_W, M_XRD, 32'h800, 32'h0, 32'h13572468, 0, 1'b1, 32'h800, 4'hF, 32'h0, 1'b0, 1'b1, 32'h13572468, 3, 0});
    bus_rsp_valid = 1'b1;
    bus_req_ready = 1'b1;
    bus_rdata = 32'h55555555;
    repeat (2) @(negedge clk);
    #1;
    check_output("idle rsp ignored", dmem_out.res.data, 32'h13572468);
    check_output("idle no bus request", {31'h0, bus_req_valid}, 32'h0);
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b0;

    // Reset while waiting for load data; the late response must be dropped.
    dmem_in.req_valid = 1'b1;
    dmem_in.req.addr  = 32'h600;
    dmem_in.req.fcn   = M_XRD;
    dmem_in.req.typ   = MT_W;
    dmem_in.req.data  = 32'h0;
    @(negedge clk);
    #1;
    check_output("reset-seq request raised", {31'h0, bus_req_valid}, 32'h1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    reset = 1'b1;
    dmem_in.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    #1;
    check_output("post-reset stall", {31'h0, cmiss_stall}, 32'h0);
    check_output("post-reset bus_req_valid", {31'h0, bus_req_valid}, 32'h0);
    check_output("post-reset res.data", dmem_out.res.data, 32'h0);
    @(negedge clk);
    #1;
    check_output("post-reset res.data held", dmem_out.res.data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
